// File: rtl/weight_pkg.sv
// Shared types, state encodings and address helper for the weight server and its clients.
package weight_pkg;

    localparam int unsigned N_DEFAULT      = 100;
    localparam int unsigned LAYERS_DEFAULT = 4;
    localparam int unsigned FRAC_BITS      = 16;

    // Signed Q16.16 fixed-point weight.
    typedef logic signed [31:0] weight_t;

    typedef logic [2:0] state_t;

    localparam state_t StIdle    = 3'd0;
    localparam state_t StRdIssue = 3'd1;
    localparam state_t StRdData  = 3'd2;
    localparam state_t StResp    = 3'd3;
    localparam state_t StWr      = 3'd4;

    // Flat weight address: layer matrices are stored back to back, row = right node.
    function automatic int unsigned weight_addr(input int unsigned num,
                                                input int unsigned right,
                                                input int unsigned left,
                                                input int unsigned n = N_DEFAULT);
        return num * n * n + n * right + left;
    endfunction

endpackage

// File: rtl/weight_server_if.sv
// Weight-read handshake plus host load port, grouped as one bus.
interface weight_server_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
);
    logic              read;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] rdata;
    logic              resp;
    logic              err;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              load_ack;
    logic              busy;

    // Requester / host side.
    modport master (
        output read, address, load_en, load_addr, load_data,
        input  rdata, resp, err, load_ack, busy
    );

    // Weight server side.
    modport slave (
        input  read, address, load_en, load_addr, load_data,
        output rdata, resp, err, load_ack, busy
    );
endinterface

// File: rtl/weight_ram.sv
// Single-port synchronous weight RAM, one-cycle read latency, no reset so it maps to block RAM.
module weight_ram #(
    parameter int unsigned DEPTH  = 40000,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Read-first port: write when enabled, always register the addressed word.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/weight_server.sv
// Weight server: serves single-outstanding weight reads and host writes from an on-chip RAM.
module weight_server
    import weight_pkg::*;
#(
    parameter int unsigned N      = N_DEFAULT,
    parameter int unsigned LAYERS = LAYERS_DEFAULT,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = LAYERS * N * N,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    weight_server_if.slave  bus
);
    // One extra bit so the compare also works when DEPTH is a power of two.
    localparam logic [ADDR_W:0] DepthW = DEPTH[ADDR_W:0];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              oor_q, oor_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              armed_q, armed_d;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DepthW;
    endfunction

    // Next-state logic for the handshake FSM, latched request and armed flag.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        oor_d   = oor_q;
        rdata_d = rdata_q;
        armed_d = armed_q;
        case (state_q)
            StIdle: begin
                if (bus.read && armed_q) begin
                    addr_d  = bus.address;
                    oor_d   = !in_range(bus.address);
                    state_d = StRdIssue;
                end else if (bus.load_en) begin
                    state_d = StWr;
                end
            end
            StRdIssue: state_d = StRdData;
            StRdData: begin
                rdata_d = oor_q ? '0 : ram_rdata;
                state_d = StResp;
            end
            StResp: begin
                armed_d = 1'b0;
                state_d = StIdle;
            end
            StWr:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // A low read always re-arms, even in the response cycle.
        if (!bus.read) begin
            armed_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset; RAM contents are untouched.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            oor_q   <= 1'b0;
            rdata_q <= '0;
            armed_q <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            oor_q   <= oor_d;
            rdata_q <= rdata_d;
            armed_q <= armed_d;
        end
    end

    // RAM port steering; out-of-range addresses never reach the array.
    always_comb begin
        ram_we   = (state_q == StWr) && in_range(bus.load_addr);
        ram_addr = '0;
        if (state_q == StWr) begin
            if (ram_we) begin
                ram_addr = bus.load_addr;
            end
        end else if (!oor_q) begin
            ram_addr = addr_q;
        end
    end

    weight_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (bus.load_data),
        .rdata_o (ram_rdata)
    );

    assign bus.rdata    = rdata_q;
    assign bus.resp     = (state_q == StResp);
    assign bus.err      = (state_q == StResp) && oor_q;
    assign bus.load_ack = (state_q == StWr);
    assign bus.busy     = (state_q != StIdle);
endmodule

// File: tb/tb_weight_server.sv
// Self-checking bench for weight_server: randomized loads/reads against an address->weight map.
module tb_weight_server;
    import weight_pkg::*;

    localparam int unsigned DEPTH = LAYERS_DEFAULT * N_DEFAULT * N_DEFAULT;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    // Reference model: only addresses that were written are ever read back.
    logic [31:0] model_mem [int unsigned];

    always #5 clk = ~clk;

    weight_server_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    weight_server dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Host write; returns whether load_ack arrived within the budget. Ends with the DUT idle.
    task automatic do_load(input logic [15:0] a, input logic [31:0] d, output logic acked);
        bus.load_en   = 1'b1;
        bus.load_addr = a;
        bus.load_data = d;
        acked = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.load_ack) begin
                acked = 1'b1;
                break;
            end
        end
        bus.load_en = 1'b0;
        @(negedge clk);
        if (acked && a < DEPTH) model_mem[32'(a)] = d;
    endtask

    // Read; lat counts negedges from raising read to seeing resp (3 = resp sampled at edge t+3).
    task automatic do_read(input logic [15:0] a, output logic [31:0] d, output logic e,
                           output int lat);
        bus.read    = 1'b1;
        bus.address = a;
        lat = -1;
        d   = '0;
        e   = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.resp) begin
                lat = i;
                d   = bus.rdata;
                e   = bus.err;
                break;
            end
        end
        bus.read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks += 5;
        if (bus.resp !== 1'b0) begin failures++; $display("FAIL reset_resp got=%b exp=0", bus.resp); end
        if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err); end
        if (bus.load_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", bus.load_ack); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        if (bus.rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata); end
    endtask

    task automatic test_load_read;
        logic        ack;
        logic [31:0] d;
        logic        e;
        int          lat;
        logic [15:0] addrs [$];
        do_load(16'h0123, 32'd3 << (FRAC_BITS - 1), ack);
        checks++;
        if (!ack) begin failures++; $display("FAIL load_ack_0123 got=0 exp=1"); end
        do_read(16'h0123, d, e, lat);
        checks += 3;
        if (lat != 3) begin failures++; $display("FAIL read_latency got=%0d exp=3", lat); end
        if (d !== 32'h0001_8000) begin failures++; $display("FAIL read_0123 got=%h exp=00018000", d); end
        if (e !== 1'b0) begin failures++; $display("FAIL read_0123_err got=%b exp=0", e); end
        // Random layer/row/column coordinates with random data.
        for (int i = 0; i < 8; i++) begin
            int unsigned wa;
            wa = weight_addr($urandom_range(LAYERS_DEFAULT - 1), $urandom_range(N_DEFAULT - 1),
                             $urandom_range(N_DEFAULT - 1));
            do_load(wa[15:0], $urandom, ack);
            addrs.push_back(wa[15:0]);
            checks++;
            if (!ack) begin failures++; $display("FAIL rand_load_ack addr=%h got=0 exp=1", wa[15:0]); end
        end
        addrs.shuffle();
        foreach (addrs[i]) begin
            do_read(addrs[i], d, e, lat);
            checks++;
            if (lat != 3 || e !== 1'b0 || d !== model_mem[32'(addrs[i])]) begin
                failures++;
                $display("FAIL rand_read addr=%h got=%h/err%b/lat%0d exp=%h/err0/lat3",
                         addrs[i], d, e, lat, model_mem[32'(addrs[i])]);
            end
        end
    endtask

    task automatic test_held_read;
        logic        ack;
        logic [31:0] d;
        logic        e;
        int          lat;
        int          pulses;
        do_load(16'd5, $urandom, ack);
        bus.read    = 1'b1;
        bus.address = 16'd5;
        pulses = 0;
        for (int i = 0; i < 4 + 6; i++) begin
            @(negedge clk);
            if (bus.resp) pulses++;
        end
        checks++;
        if (pulses != 1) begin failures++; $display("FAIL held_read_pulses got=%0d exp=1", pulses); end
        bus.read = 1'b0;
        @(negedge clk);
        do_read(16'd5, d, e, lat);
        checks++;
        if (lat != 3 || d !== model_mem[32'd5]) begin
            failures++;
            $display("FAIL rearm_read got=%h/lat%0d exp=%h/lat3", d, lat, model_mem[32'd5]);
        end
    endtask

    task automatic test_collision;
        logic        ack;
        logic [31:0] old;
        logic [31:0] d;
        logic        e;
        int          lat;
        int          resp_cyc;
        int          ack_cyc;
        logic [31:0] rd_seen;
        old = $urandom;
        do_load(16'd7, old, ack);
        bus.read      = 1'b1;
        bus.address   = 16'd7;
        bus.load_en   = 1'b1;
        bus.load_addr = 16'd7;
        bus.load_data = 32'hFFFF_0000;
        resp_cyc = -1;
        ack_cyc  = -1;
        rd_seen  = '0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bus.resp && resp_cyc < 0) begin
                resp_cyc = i;
                rd_seen  = bus.rdata;
                bus.read = 1'b0;
            end
            if (bus.load_ack && ack_cyc < 0) begin
                ack_cyc = i;
                bus.load_en = 1'b0;
            end
            if (resp_cyc > 0 && ack_cyc > 0) break;
        end
        bus.read    = 1'b0;
        bus.load_en = 1'b0;
        @(negedge clk);
        checks += 2;
        if (resp_cyc != 3 || ack_cyc <= resp_cyc) begin
            failures++;
            $display("FAIL collision_order got=resp%0d/ack%0d exp=resp3/ack_after", resp_cyc, ack_cyc);
        end
        if (rd_seen !== old) begin failures++; $display("FAIL collision_old got=%h exp=%h", rd_seen, old); end
        if (ack_cyc > 0) model_mem[32'd7] = 32'hFFFF_0000;
        do_read(16'd7, d, e, lat);
        checks++;
        if (d !== 32'hFFFF_0000 || lat != 3) begin
            failures++;
            $display("FAIL collision_new got=%h/lat%0d exp=ffff0000/lat3", d, lat);
        end
    endtask

    task automatic test_out_of_range;
        logic        ack;
        logic [31:0] d;
        logic        e;
        int          lat;
        logic [15:0] a;
        do_read(16'(DEPTH), d, e, lat);
        checks++;
        if (lat != 3 || e !== 1'b1 || d !== 32'h0) begin
            failures++;
            $display("FAIL oor_read_depth got=%h/err%b/lat%0d exp=0/err1/lat3", d, e, lat);
        end
        a = 16'($urandom_range(65535, DEPTH));
        do_read(a, d, e, lat);
        checks++;
        if (lat != 3 || e !== 1'b1 || d !== 32'h0) begin
            failures++;
            $display("FAIL oor_read_rand addr=%h got=%h/err%b exp=0/err1", a, d, e);
        end
        do_load(16'(DEPTH - 1), $urandom, ack);
        do_read(16'(DEPTH - 1), d, e, lat);
        checks++;
        if (e !== 1'b0 || d !== model_mem[DEPTH - 1]) begin
            failures++;
            $display("FAIL last_word got=%h/err%b exp=%h/err0", d, e, model_mem[DEPTH - 1]);
        end
        do_load(16'(DEPTH), 32'hDEAD_BEEF, ack);
        checks++;
        if (!ack) begin failures++; $display("FAIL oor_load_ack got=0 exp=1"); end
        foreach (model_mem[k]) begin
            do_read(k[15:0], d, e, lat);
            checks++;
            if (d !== model_mem[k] || e !== 1'b0) begin
                failures++;
                $display("FAIL oor_load_intact addr=%h got=%h exp=%h", k[15:0], d, model_mem[k]);
            end
        end
    endtask

    task automatic test_reset_mid_read;
        logic        ack;
        logic [31:0] d;
        logic        e;
        int          lat;
        int          pulses;
        do_load(16'd4242, $urandom, ack);
        bus.read    = 1'b1;
        bus.address = 16'd4242;
        repeat (2) @(negedge clk);
        // The DUT is now in the data-capture cycle.
        reset    = 1'b0;
        bus.read = 1'b0;
        @(negedge clk);
        pulses = bus.resp ? 1 : 0;
        checks += 2;
        if (bus.rdata !== 32'h0) begin failures++; $display("FAIL midreset_rdata got=%h exp=0", bus.rdata); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", bus.busy); end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.resp) pulses++;
        end
        checks++;
        if (pulses != 0) begin failures++; $display("FAIL midreset_resp got=%0d exp=0", pulses); end
        do_read(16'd4242, d, e, lat);
        checks++;
        if (lat != 3 || d !== model_mem[32'd4242] || e !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_read got=%h/lat%0d exp=%h/lat3", d, lat, model_mem[32'd4242]);
        end
    endtask

    initial begin
        bus.read      = 1'b0;
        bus.address   = '0;
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        test_reset();
        test_load_read();
        test_held_read();
        test_collision();
        test_out_of_range();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so a wedged DUT still ends the run.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule

// File: doc/weight_server.md
Name: weight_server

Overview:
- Responder end of the layer weight-read handshake. A layer drives `read` plus a flat `address` (num*N*N + N*right_node + left_node); this block returns one weight and pulses `resp`.
- Holds all layer weights in an on-chip synchronous RAM. A host-side load port writes the RAM before and between inference passes.
- Sits between the layer sequencer(s) and weight storage. Weights are fixed-point for synthesis.

Parameters:
- N, 100, nodes per layer (matrix is N x N per layer)
- LAYERS, 4, number of layers stored
- DATA_W, 32, weight width, signed Q16.16
- DEPTH, LAYERS*N*N, RAM words (derived)
- ADDR_W, $clog2(DEPTH), address width (derived; 16 at defaults)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- read  in  1  read request, held by requester until resp
- address  in  ADDR_W  weight address, stable while read high
- rdata  out  DATA_W  weight data, valid in resp cycle
- resp  out  1  one-cycle response pulse
- err  out  1  pulses with resp when address >= DEPTH
- load_en  in  1  host write request, held until load_ack
- load_addr  in  ADDR_W  host write address
- load_data  in  DATA_W  host write data
- load_ack  out  1  one-cycle write acknowledge
- busy  out  1  high whenever state != IDLE

Behaviour:
Reset (clk edge with reset==0):
- State goes to IDLE; resp, err, load_ack and busy go to 0; rdata goes to 0; the armed flag is set to 1.
- RAM contents are not cleared.
- Reset mid-read drops the pending request and no resp is issued for it.

State machine:
- IDLE
  - If read && armed: latch address, go to RD_ISSUE.
  - Otherwise, if load_en: go to WR.
- RD_ISSUE: RAM read issued at the latched address; go to RD_DATA.
- RD_DATA: RAM output is captured into rdata; go to RESP.
  - If the latched address >= DEPTH, rdata is 0 and err will assert.
- RESP: resp=1 (and err=1 if out of range) for exactly this cycle; armed is cleared; go to IDLE.
- WR: RAM write at load_addr with load_data when load_addr < DEPTH; out-of-range writes are dropped silently. load_ack=1 this cycle; go to IDLE.

Timing and handshake:
- Latency: read sampled high in IDLE at edge t gives resp high in cycle t+3.
- Single outstanding request; no pipelining.
- Re-arm rule: armed is set on any edge where read==0. This prevents a read still held after resp from being served twice. A new request needs read low for at least 1 cycle between transactions.
- rdata holds its last value until the next RD_DATA capture.

Priority and boundaries:
- Simultaneous read && armed and load_en in IDLE: read wins; load_ack is delayed until the next IDLE with no armed read.
- load_en asserted while busy: stalls (no ack) until serviced.
- Write then read of the same address in back-to-back transactions returns the new data; no read-during-write hazard, since the two never share a cycle.
- Address width rule: no truncation; a range check against DEPTH is done on the full ADDR_W value.

Decomposition:
- Package weight_pkg:
  - weight_t (logic signed [31:0], Q16.16)
  - state enum {IDLE, RD_ISSUE, RD_DATA, RESP, WR}
  - constants FRAC_BITS=16, default N/LAYERS
  - function weight_addr(num, right, left), also used by the layer.
- Sub-module weight_ram:
  - single-port synchronous RAM of DEPTH x DATA_W
  - 1-cycle read latency, write-enable, no reset
  - keeps inference-friendly memory separate from the FSM.

Test Plan:
- Reset with reset=0 for 2 cycles, then release -> resp=0, err=0, load_ack=0, busy=0, rdata=0.
- Load address 0x0123 with 0x0001_8000 (1.5); after load_ack, read 0x0123 -> resp exactly 3 cycles after read sampled, rdata=0x0001_8000, err=0.
- Keep read high for 6 cycles after resp on address 5 -> exactly one resp pulse. Drop read 1 cycle and raise again -> second resp.
- Assert read (address 7) and load_en (address 7, data 0xFFFF_0000) in the same IDLE cycle -> read served first with the old data, then load_ack; a subsequent read returns 0xFFFF_0000.
- Read address DEPTH (40000) -> resp with err=1, rdata=0. A load to 40000 gets load_ack but RAM is unchanged.
- Drive reset=0 in RD_DATA -> no resp. After release, an armed fresh read returns correct data with resp at t+3.
